// File: rtl/ccip_host_mem_responder.sv
// ccip_host_mem_responder
// FIU-side host-memory model for AFU benches. It accepts c0 read-line and
// c1 write-line requests against a small aliased cache-line memory. Each
// request produces a response after a fixed latency, delivered through a
// per-channel in-order response FIFO.
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   c0_req_* / c1_req_*          read / write request strobes, address, data, tag
//   rsp_stall                    holds off all responses while high
//   bd_wr_en/bd_addr/bd_data     backdoor line preload
//   c0TxAlmFull / c1TxAlmFull    FIFO count >= ALMFULL_THRESH
//   c0_rsp_* / c1_rsp_*          registered response strobes, data, tags
//   overflow_err                 sticky: a request arrived at a full FIFO
//   rd_rsp_count / wr_rsp_count  responses delivered, wrapping 32-bit

// One response channel. It is an in-order FIFO whose entries carry a
// latency countdown, plus registered response outputs.
//
// Ports
//   req_valid/req_payload   request strobe and payload to queue
//   rsp_stall               blocks pops while high
//   req_accept              request taken this cycle
//   almfull                 count >= ALMFULL_THRESH
//   rsp_valid/rsp_payload   registered response
//   rsp_count               responses delivered
//   overflow_err            sticky drop flag
module ccip_rsp_chan #(
  parameter int PW             = 16,
  parameter int LATENCY        = 4,
  parameter int Q_DEPTH        = 8,
  parameter int ALMFULL_THRESH = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  input  logic [PW-1:0] req_payload,
  input  logic          rsp_stall,
  output logic          req_accept,
  output logic          almfull,
  output logic          rsp_valid,
  output logic [PW-1:0] rsp_payload,
  output logic [31:0]   rsp_count,
  output logic          overflow_err
);
  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PW-1:0]    pay_q [Q_DEPTH];
  logic [7:0]       rem_q [Q_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             head_ready, pop, bypass, push;

  // rem_q holds the cycles still owed. The output stage is registered, so
  // the head pops on the edge where its countdown reaches 0 (value <= 1
  // now). This places the response in cycle LATENCY after the request.
  assign head_ready = (count != '0) && (rem_q[rd_ptr] <= 8'd1);
  assign pop        = head_ready && !rsp_stall;
  // A pop in the same cycle frees a slot for a push into a full FIFO.
  assign req_accept = req_valid && ((count != CNT_W'(Q_DEPTH)) || pop);
  // LATENCY 1 has no countdown left at acceptance. When nothing is queued
  // and no stall is active, the request goes straight to the output register.
  assign bypass     = (LATENCY == 1) && req_accept && (count == '0) && !rsp_stall;
  assign push       = req_accept && !bypass;
  assign almfull    = count >= CNT_W'(ALMFULL_THRESH);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      rsp_valid    <= 1'b0;
      rsp_count    <= '0;
      overflow_err <= 1'b0;
    end else begin
      rsp_valid <= pop || bypass;
      if (pop || bypass) rsp_count <= rsp_count + 32'd1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (req_valid && !req_accept) overflow_err <= 1'b1;
    end
  end

  // Payload storage and countdowns need no reset. They are only examined
  // for slots that are counted as occupied.
  always_ff @(posedge clk) begin
    for (int i = 0; i < Q_DEPTH; i++)
      if (rem_q[i] != 8'd0) rem_q[i] <= rem_q[i] - 8'd1;
    if (push) begin
      rem_q[wr_ptr] <= 8'(LATENCY - 1);
      pay_q[wr_ptr] <= req_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (pop)         rsp_payload <= pay_q[rd_ptr];
    else if (bypass) rsp_payload <= req_payload;
  end
endmodule

module ccip_host_mem_responder #(
  parameter int ADDR_W         = 42,
  parameter int DATA_W         = 512,
  parameter int MDATA_W        = 16,
  parameter int MEM_LINES      = 64,
  parameter int RD_LATENCY     = 4,
  parameter int WR_LATENCY     = 2,
  parameter int Q_DEPTH        = 8,
  parameter int ALMFULL_THRESH = 6
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         c0_req_valid,
  input  logic [ADDR_W-1:0]            c0_req_addr,
  input  logic [MDATA_W-1:0]           c0_req_mdata,
  input  logic                         c1_req_valid,
  input  logic [ADDR_W-1:0]            c1_req_addr,
  input  logic [DATA_W-1:0]            c1_req_data,
  input  logic [MDATA_W-1:0]           c1_req_mdata,
  input  logic                         rsp_stall,
  input  logic                         bd_wr_en,
  input  logic [$clog2(MEM_LINES)-1:0] bd_addr,
  input  logic [DATA_W-1:0]            bd_data,
  output logic                         c0TxAlmFull,
  output logic                         c1TxAlmFull,
  output logic                         c0_rsp_valid,
  output logic [DATA_W-1:0]            c0_rsp_data,
  output logic [MDATA_W-1:0]           c0_rsp_mdata,
  output logic                         c1_rsp_valid,
  output logic [MDATA_W-1:0]           c1_rsp_mdata,
  output logic                         overflow_err,
  output logic [31:0]                  rd_rsp_count,
  output logic [31:0]                  wr_rsp_count
);
  localparam int LINE_W = $clog2(MEM_LINES);

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [MDATA_W-1:0] mdata;
  } rd_ent_t;

  logic [DATA_W-1:0] mem [MEM_LINES];
  logic [LINE_W-1:0] c0_idx, c1_idx;
  logic              c0_accept, c1_accept, c0_ovf, c1_ovf;
  rd_ent_t           c0_req_ent, c0_rsp_ent;

  // Upper address bits alias onto the modelled lines.
  assign c0_idx = c0_req_addr[LINE_W-1:0];
  assign c1_idx = c1_req_addr[LINE_W-1:0];

  logic unused_addr_hi;
  assign unused_addr_hi = ^{c0_req_addr[ADDR_W-1:LINE_W], c1_req_addr[ADDR_W-1:LINE_W]};

  // The read samples the array before this edge's write lands, so a
  // same-cycle read and write of one line returns the old data.
  assign c0_req_ent = '{data: mem[c0_idx], mdata: c0_req_mdata};

  // A committed c1 write takes the single write port and drops any
  // backdoor write in the same cycle. Requests during reset never commit.
  always_ff @(posedge clk) begin
    if (reset_n && c1_accept) mem[c1_idx]  <= c1_req_data;
    else if (bd_wr_en)        mem[bd_addr] <= bd_data;
  end

  ccip_rsp_chan #(
    .PW($bits(rd_ent_t)), .LATENCY(RD_LATENCY),
    .Q_DEPTH(Q_DEPTH), .ALMFULL_THRESH(ALMFULL_THRESH)
  ) u_c0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(c0_req_valid), .req_payload(c0_req_ent),
    .rsp_stall(rsp_stall), .req_accept(c0_accept), .almfull(c0TxAlmFull),
    .rsp_valid(c0_rsp_valid), .rsp_payload(c0_rsp_ent),
    .rsp_count(rd_rsp_count), .overflow_err(c0_ovf)
  );

  ccip_rsp_chan #(
    .PW(MDATA_W), .LATENCY(WR_LATENCY),
    .Q_DEPTH(Q_DEPTH), .ALMFULL_THRESH(ALMFULL_THRESH)
  ) u_c1 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(c1_req_valid), .req_payload(c1_req_mdata),
    .rsp_stall(rsp_stall), .req_accept(c1_accept), .almfull(c1TxAlmFull),
    .rsp_valid(c1_rsp_valid), .rsp_payload(c1_rsp_mdata),
    .rsp_count(wr_rsp_count), .overflow_err(c1_ovf)
  );

  assign c0_rsp_data  = c0_rsp_ent.data;
  assign c0_rsp_mdata = c0_rsp_ent.mdata;
  assign overflow_err = c0_ovf | c1_ovf;

  logic unused_c0_accept;
  assign unused_c0_accept = c0_accept;
endmodule

// File: tb/tb_ccip_host_mem_responder.sv
// Directed bench for ccip_host_mem_responder with default parameters
// (RD_LATENCY 4, WR_LATENCY 2, Q_DEPTH 8, ALMFULL_THRESH 6, MEM_LINES 64).
// Inputs change 1 time unit after a rising edge. Outputs are sampled at that
// same point, so they reflect the edge just taken. "Cycle 0" is the cycle in
// which a request is presented.
module tb_ccip_host_mem_responder;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         c0_req_valid, c1_req_valid, rsp_stall, bd_wr_en;
  logic [41:0]  c0_req_addr, c1_req_addr;
  logic [15:0]  c0_req_mdata, c1_req_mdata;
  logic [511:0] c1_req_data, bd_data;
  logic [5:0]   bd_addr;
  logic         c0TxAlmFull, c1TxAlmFull, c0_rsp_valid, c1_rsp_valid, overflow_err;
  logic [511:0] c0_rsp_data;
  logic [15:0]  c0_rsp_mdata, c1_rsp_mdata;
  logic [31:0]  rd_rsp_count, wr_rsp_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ccip_host_mem_responder dut (
    .clk(clk), .reset_n(reset_n),
    .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr), .c0_req_mdata(c0_req_mdata),
    .c1_req_valid(c1_req_valid), .c1_req_addr(c1_req_addr), .c1_req_data(c1_req_data),
    .c1_req_mdata(c1_req_mdata), .rsp_stall(rsp_stall),
    .bd_wr_en(bd_wr_en), .bd_addr(bd_addr), .bd_data(bd_data),
    .c0TxAlmFull(c0TxAlmFull), .c1TxAlmFull(c1TxAlmFull),
    .c0_rsp_valid(c0_rsp_valid), .c0_rsp_data(c0_rsp_data), .c0_rsp_mdata(c0_rsp_mdata),
    .c1_rsp_valid(c1_rsp_valid), .c1_rsp_mdata(c1_rsp_mdata),
    .overflow_err(overflow_err), .rd_rsp_count(rd_rsp_count), .wr_rsp_count(wr_rsp_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read with no stall and an empty queue: the response appears in cycle 4 only.
  task automatic do_read(input logic [41:0] addr, input logic [15:0] md, input logic [511:0] exp);
    c0_req_valid = 1'b1; c0_req_addr = addr; c0_req_mdata = md;
    step();
    c0_req_valid = 1'b0;
    chk("rd_c1_idle", c0_rsp_valid, 1'b0);
    step(); chk("rd_c2_idle", c0_rsp_valid, 1'b0);
    step(); chk("rd_c3_idle", c0_rsp_valid, 1'b0);
    step();
    chk("rd_c4_valid", c0_rsp_valid, 1'b1);
    chk("rd_c4_data", c0_rsp_data, exp);
    chk("rd_c4_mdata", c0_rsp_mdata, md);
    step(); chk("rd_c5_idle", c0_rsp_valid, 1'b0);
  endtask

  // Write: the response appears in cycle 2 only.
  task automatic do_write(input logic [41:0] addr, input logic [511:0] d, input logic [15:0] md);
    c1_req_valid = 1'b1; c1_req_addr = addr; c1_req_data = d; c1_req_mdata = md;
    step();
    c1_req_valid = 1'b0;
    chk("wr_c1_idle", c1_rsp_valid, 1'b0);
    step();
    chk("wr_c2_valid", c1_rsp_valid, 1'b1);
    chk("wr_c2_mdata", c1_rsp_mdata, md);
    step(); chk("wr_c3_idle", c1_rsp_valid, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    c0_req_valid = 1'b0; c0_req_addr = '0; c0_req_mdata = '0;
    c1_req_valid = 1'b0; c1_req_addr = '0; c1_req_data = '0; c1_req_mdata = '0;
    rsp_stall = 1'b0;
    // Backdoor preload of line 3 during reset.
    bd_wr_en = 1'b1; bd_addr = 6'd3; bd_data = 512'h0102;
    step();
    bd_wr_en = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    chk("rst_c0_valid", c0_rsp_valid, 1'b0);
    chk("rst_c1_valid", c1_rsp_valid, 1'b0);
    chk("rst_c0_almfull", c0TxAlmFull, 1'b0);
    chk("rst_c1_almfull", c1TxAlmFull, 1'b0);
    chk("rst_overflow", overflow_err, 1'b0);
    chk("rst_rd_count", rd_rsp_count, 32'd0);
    chk("rst_wr_count", wr_rsp_count, 32'd0);

    // Preloaded read, latency 4.
    do_read(42'd3, 16'h00A5, 512'h0102);
    chk("rd_count_1", rd_rsp_count, 32'd1);

    // Write then read back.
    do_write(42'd3, 512'd50, 16'h0011);
    chk("wr_count_1", wr_rsp_count, 32'd1);
    do_read(42'd3, 16'h0001, 512'd50);

    // Same-cycle read and write of line 3: the read sees the old value.
    do_write(42'd3, 512'd7, 16'h0002);
    c0_req_valid = 1'b1; c0_req_addr = 42'd3; c0_req_mdata = 16'h0003;
    c1_req_valid = 1'b1; c1_req_addr = 42'd3; c1_req_data = 512'd9; c1_req_mdata = 16'h0004;
    step();
    c0_req_valid = 1'b0; c1_req_valid = 1'b0;
    step();
    chk("rw_wr_valid", c1_rsp_valid, 1'b1);
    chk("rw_wr_mdata", c1_rsp_mdata, 16'h0004);
    step();
    chk("rw_rd_c3_idle", c0_rsp_valid, 1'b0);
    step();
    chk("rw_rd_valid", c0_rsp_valid, 1'b1);
    chk("rw_rd_old_data", c0_rsp_data, 512'd7);
    step();
    // Address 67 aliases onto line 3.
    do_read(42'd67, 16'h0005, 512'd9);

    // A c1 write and a backdoor write to line 5 in the same cycle: c1 wins.
    bd_wr_en = 1'b1; bd_addr = 6'd5; bd_data = 512'hBB;
    c1_req_valid = 1'b1; c1_req_addr = 42'd5; c1_req_data = 512'hAA; c1_req_mdata = 16'h0006;
    step();
    bd_wr_en = 1'b0; c1_req_valid = 1'b0;
    step(); step();
    do_read(42'd5, 16'h0007, 512'hAA);
    chk("rd_count_5", rd_rsp_count, 32'd5);
    chk("wr_count_4", wr_rsp_count, 32'd4);

    // Stalled fill: almost-full from 6 entries, full at 8, the 9th overflows.
    rsp_stall = 1'b1;
    for (int i = 0; i < 9; i++) begin
      c0_req_valid = 1'b1; c0_req_addr = 42'd3; c0_req_mdata = 16'(i);
      step();
      chk("stall_almfull", c0TxAlmFull, (i >= 5) ? 1'b1 : 1'b0);
      chk("stall_overflow", overflow_err, (i == 8) ? 1'b1 : 1'b0);
      chk("stall_no_rsp", c0_rsp_valid, 1'b0);
    end
    c0_req_valid = 1'b0;
    step(); step();
    chk("stall_hold_no_rsp", c0_rsp_valid, 1'b0);
    chk("stall_hold_almfull", c0TxAlmFull, 1'b1);
    rsp_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("drain_valid", c0_rsp_valid, 1'b1);
      chk("drain_mdata", c0_rsp_mdata, 16'(i));
    end
    step();
    chk("drain_done", c0_rsp_valid, 1'b0);
    chk("drain_almfull", c0TxAlmFull, 1'b0);
    chk("drain_overflow_sticky", overflow_err, 1'b1);
    chk("rd_count_13", rd_rsp_count, 32'd13);

    // 10 back-to-back reads: responses in cycles 4..13, never almost-full.
    for (int k = 0; k < 16; k++) begin
      c0_req_valid = (k < 10); c0_req_addr = 42'd5; c0_req_mdata = 16'(32 + k);
      step();
      chk("b2b_valid", c0_rsp_valid, ((k + 1) >= 4 && (k + 1) <= 13) ? 1'b1 : 1'b0);
      if ((k + 1) >= 4 && (k + 1) <= 13)
        chk("b2b_mdata", c0_rsp_mdata, 16'(32 + k + 1 - 4));
      chk("b2b_almfull", c0TxAlmFull, 1'b0);
    end
    chk("rd_count_23", rd_rsp_count, 32'd23);

    // Reset in the middle of three reads: nothing emerges afterwards.
    c0_req_valid = 1'b1; c0_req_mdata = 16'h0040;
    step();
    c0_req_mdata = 16'h0041;
    step();
    c0_req_mdata = 16'h0042; reset_n = 1'b0;
    step();
    c0_req_valid = 1'b0; reset_n = 1'b1;
    chk("mrst_rd_count", rd_rsp_count, 32'd0);
    chk("mrst_wr_count", wr_rsp_count, 32'd0);
    chk("mrst_overflow", overflow_err, 1'b0);
    chk("mrst_almfull", c0TxAlmFull, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("mrst_no_rsp", c0_rsp_valid, 1'b0);
    end
    chk("mrst_rd_count_end", rd_rsp_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
